// File: rtl/cpu_pkg.sv
// Shared definitions for cpu_core and its on-chip memory responder: instruction
// format encodings, the fetch-length rule and the responder FSM states.
package cpu_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_LD   = 4'h3,
        OP_ST   = 4'h4,
        OP_HALT = 4'hF
    } opcode_t;

    typedef enum logic [1:0] {
        R_TYPE  = 2'b00,
        I_TYPE  = 2'b01,
        M_TYPE  = 2'b10,
        SYS_END = 2'b11
    } fmt_t;

    // 16-bit instruction word; the format field sits in the low bits so the
    // responder can size a fetch from the first word alone.
    typedef struct packed {
        opcode_t    op;
        logic [2:0] rd;
        logic [2:0] rs1;
        logic [3:0] rs2;
        fmt_t       fmt;
    } instr_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PC_COL   = 3'd1,
        ST_FETCH_TX = 3'd2,
        ST_MAR_COL  = 3'd3,
        ST_DECIDE   = 3'd4,
        ST_MDR_COL  = 3'd5,
        ST_LOAD_TX  = 3'd6
    } state_t;

    function automatic logic [1:0] fetch_words(input fmt_t fmt);
        return ((fmt == R_TYPE) || (fmt == SYS_END)) ? 2'd1 : 2'd2;
    endfunction

endpackage

// File: rtl/serial_mem_responder_byte_shift_reg.sv
// LSB-first byte shifter: bytes enter at the top and move down, so after W/BUS_W
// shifts q holds the assembled word and q's low byte is always the next byte out.
module byte_shift_reg #(
    parameter int W     = 16,
    parameter int BUS_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [W-1:0]     load_data,
    input  logic [BUS_W-1:0] sin,
    output logic [W-1:0]     q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= load_data;
        end else if (shift) begin
            q <= {sin, q[W-1:BUS_W]};
        end
    end

endmodule

// File: rtl/serial_mem_responder.sv
// On-chip instruction/data memory agent for cpu_core's byte-wide host bus.
// Optional SERMEM_BOUNDS_CHECK_EN: out-of-range accesses read 0 / drop writes and set sticky err.
module serial_mem_responder
    import cpu_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int BUS_W      = 8,
    parameter int ADDR_W     = 16,
    parameter int IMEM_DEPTH = 16,
    parameter int DMEM_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BUS_W-1:0]  out_bus,
    input  logic              bus_pc,
    input  logic              bus_mar,
    input  logic              bus_mdr,
    output logic [BUS_W-1:0]  in_bus,
    output logic              ard_data_ready,
    output logic              ard_receive_ready,
    input  logic              imem_we,
    input  logic [ADDR_W-1:0] imem_waddr,
    input  logic [DATA_W-1:0] imem_wdata,
    input  logic [ADDR_W-1:0] dmem_raddr,
    output logic [DATA_W-1:0] dmem_rdata,
    output logic              err
);

    // Handshake: the CPU may present an out_bus byte only while ard_receive_ready is 1;
    // in_bus carries a byte exactly in the cycles ard_data_ready is 1, with no stalls.
    localparam int NB  = ADDR_W / BUS_W;
    localparam int NW  = DATA_W / BUS_W;
    localparam int IIW = $clog2(IMEM_DEPTH);
    localparam int DIW = $clog2(DMEM_DEPTH);
    localparam int CW  = $clog2(((NB > NW) ? NB : NW) + 1);

    logic [DATA_W-1:0] imem [IMEM_DEPTH];
    logic [DATA_W-1:0] dmem [DMEM_DEPTH];

    state_t            state, state_n;
    logic [CW-1:0]     byte_cnt, cnt_n;
    logic              second_q, second_n;
    logic [1:0]        nwords_q, nwords_n;
    logic              ready_q, ready_n;
    logic              rr_q;

    logic              addr_shift;
    logic [ADDR_W-1:0] addr_q, addr_next, fetch_addr;
    logic              dat_load, dat_shift;
    logic [DATA_W-1:0] dat_load_data, dat_q, store_data;
    logic [DATA_W-1:0] iword, dword;
    logic              fetch_latch, dmem_we;
    logic              i_ok, d_ok, iw_ok, dr_ok;

    function automatic logic [IIW-1:0] imem_idx(input logic [ADDR_W-1:0] a);
        return IIW'(a % ADDR_W'(IMEM_DEPTH));
    endfunction

    function automatic logic [DIW-1:0] dmem_idx(input logic [ADDR_W-1:0] a);
        return DIW'(a % ADDR_W'(DMEM_DEPTH));
    endfunction

    byte_shift_reg #(.W(ADDR_W), .BUS_W(BUS_W)) u_addr_sr (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (1'b0),
        .shift     (addr_shift),
        .load_data ('0),
        .sin       (out_bus),
        .q         (addr_q)
    );

    byte_shift_reg #(.W(DATA_W), .BUS_W(BUS_W)) u_data_sr (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (dat_load),
        .shift     (dat_shift),
        .load_data (dat_load_data),
        .sin       (out_bus),
        .q         (dat_q)
    );

    // Address including the byte on out_bus this cycle, so the last address byte
    // can select the first word without an extra cycle.
    assign addr_next  = {out_bus, addr_q[ADDR_W-1:BUS_W]};
    assign store_data = {out_bus, dat_q[DATA_W-1:BUS_W]};
    assign fetch_addr = (state == ST_FETCH_TX) ? addr_q + 1'b1 : addr_next;

`ifdef SERMEM_BOUNDS_CHECK_EN
    assign i_ok  = fetch_addr < ADDR_W'(IMEM_DEPTH);
    assign d_ok  = addr_q     < ADDR_W'(DMEM_DEPTH);
    assign iw_ok = imem_waddr < ADDR_W'(IMEM_DEPTH);
    assign dr_ok = dmem_raddr < ADDR_W'(DMEM_DEPTH);
`else
    assign i_ok  = 1'b1;
    assign d_ok  = 1'b1;
    assign iw_ok = 1'b1;
    assign dr_ok = 1'b1;
`endif

    assign iword      = i_ok  ? imem[imem_idx(fetch_addr)] : '0;
    assign dword      = d_ok  ? dmem[dmem_idx(addr_q)]     : '0;
    assign dmem_rdata = dr_ok ? dmem[dmem_idx(dmem_raddr)] : '0;

    always_comb begin
        state_n       = state;
        cnt_n         = byte_cnt;
        second_n      = second_q;
        nwords_n      = nwords_q;
        addr_shift    = 1'b0;
        dat_load      = 1'b0;
        dat_shift     = 1'b0;
        dat_load_data = iword;
        ready_n       = 1'b0;
        fetch_latch   = 1'b0;
        dmem_we       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus_pc || bus_mar) begin
                    addr_shift = 1'b1;
                    cnt_n      = CW'(1);
                    state_n    = bus_pc ? ST_PC_COL : ST_MAR_COL;
                end
            end
            ST_PC_COL: begin
                addr_shift = 1'b1;
                cnt_n      = byte_cnt + 1'b1;
                if (byte_cnt == CW'(NB - 1)) begin
                    fetch_latch = 1'b1;
                    second_n    = 1'b0;
                    nwords_n    = fetch_words(fmt_t'(iword[1:0]));
                end
            end
            ST_FETCH_TX: begin
                if (byte_cnt != CW'(NW)) begin
                    dat_shift = 1'b1;
                    ready_n   = 1'b1;
                    cnt_n     = byte_cnt + 1'b1;
                end else if (!second_q && (nwords_q == 2'd2)) begin
                    fetch_latch = 1'b1;
                    second_n    = 1'b1;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_MAR_COL: begin
                addr_shift = 1'b1;
                cnt_n      = byte_cnt + 1'b1;
                if (byte_cnt == CW'(NB - 1)) begin
                    state_n = ST_DECIDE;
                end
            end
            ST_DECIDE: begin
                cnt_n = CW'(1);
                if (bus_mdr) begin
                    dat_shift = 1'b1;
                    state_n   = ST_MDR_COL;
                end else begin
                    dat_load      = 1'b1;
                    dat_load_data = dword;
                    ready_n       = 1'b1;
                    state_n       = ST_LOAD_TX;
                end
            end
            ST_MDR_COL: begin
                dat_shift = 1'b1;
                cnt_n     = byte_cnt + 1'b1;
                if (byte_cnt == CW'(NW - 1)) begin
                    dmem_we = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            ST_LOAD_TX: begin
                if (byte_cnt != CW'(NW)) begin
                    dat_shift = 1'b1;
                    ready_n   = 1'b1;
                    cnt_n     = byte_cnt + 1'b1;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
        // Each fetched word is captured as its first byte goes out.
        if (fetch_latch) begin
            dat_load      = 1'b1;
            dat_load_data = iword;
            ready_n       = 1'b1;
            cnt_n         = CW'(1);
            state_n       = ST_FETCH_TX;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            byte_cnt <= '0;
            second_q <= 1'b0;
            nwords_q <= 2'd1;
            ready_q  <= 1'b0;
            rr_q     <= 1'b0;
        end else begin
            state    <= state_n;
            byte_cnt <= cnt_n;
            second_q <= second_n;
            nwords_q <= nwords_n;
            ready_q  <= ready_n;
            rr_q     <= (state_n != ST_FETCH_TX) && (state_n != ST_LOAD_TX);
        end
    end

    always_ff @(posedge clk) begin
        if (imem_we && iw_ok) begin
            imem[imem_idx(imem_waddr)] <= imem_wdata;
        end
        if (dmem_we && d_ok) begin
            dmem[dmem_idx(addr_q)] <= store_data;
        end
    end

    assign in_bus            = dat_q[BUS_W-1:0];
    assign ard_data_ready    = ready_q;
    assign ard_receive_ready = rr_q;

`ifdef SERMEM_BOUNDS_CHECK_EN
    logic err_q, err_set;
    assign err_set = ((state == ST_IDLE) && bus_pc && bus_mar)
                   || (fetch_latch && !i_ok)
                   || ((state == ST_DECIDE) && !bus_mdr && !d_ok)
                   || (dmem_we && !d_ok);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_q | err_set;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_mem_responder.sv
// Directed bench for serial_mem_responder: fetches, store/load, reset abort, wrap and
// out-of-range behaviour (both SERMEM_BOUNDS_CHECK_EN builds).
module tb_serial_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  out_bus = '0;
    logic        bus_pc = 1'b0;
    logic        bus_mar = 1'b0;
    logic        bus_mdr = 1'b0;
    logic [7:0]  in_bus;
    logic        ard_data_ready;
    logic        ard_receive_ready;
    logic        imem_we = 1'b0;
    logic [15:0] imem_waddr = '0;
    logic [15:0] imem_wdata = '0;
    logic [15:0] dmem_raddr = '0;
    logic [15:0] dmem_rdata;
    logic        err;

    int          total = 0;
    int          bad = 0;
    logic [7:0]  exp_q[$];

    serial_mem_responder dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .out_bus           (out_bus),
        .bus_pc            (bus_pc),
        .bus_mar           (bus_mar),
        .bus_mdr           (bus_mdr),
        .in_bus            (in_bus),
        .ard_data_ready    (ard_data_ready),
        .ard_receive_ready (ard_receive_ready),
        .imem_we           (imem_we),
        .imem_waddr        (imem_waddr),
        .imem_wdata        (imem_wdata),
        .dmem_raddr        (dmem_raddr),
        .dmem_rdata        (dmem_rdata),
        .err               (err)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        imem_we    = 1'b1;
        imem_waddr = a;
        imem_wdata = d;
        tick();
        imem_we    = 1'b0;
    endtask

    // Two address bytes, LSB first; returns in the first response cycle.
    task automatic send_addr(input logic pc, input logic mar, input logic [15:0] a);
        bus_pc  = pc;
        bus_mar = mar;
        out_bus = a[7:0];
        tick();
        bus_pc  = 1'b0;
        bus_mar = 1'b0;
        out_bus = a[15:8];
        tick();
        out_bus = '0;
    endtask

    task automatic drain(input string tag);
        while (exp_q.size() > 0) begin
            chk({tag, "_ready"}, {31'd0, ard_data_ready}, 32'd1);
            chk({tag, "_byte"}, {24'd0, in_bus}, {24'd0, exp_q.pop_front()});
            tick();
        end
        chk({tag, "_end_ready"}, {31'd0, ard_data_ready}, 32'd0);
        chk({tag, "_end_rr"}, {31'd0, ard_receive_ready}, 32'd1);
    endtask

    task automatic wait_ready(input string tag, input int max);
        int n = 0;
        while (!ard_data_ready && n < max) begin
            tick();
            n++;
        end
        chk({tag, "_timeout"}, {31'd0, ard_data_ready}, 32'd1);
    endtask

    initial begin
        // reset state
        tick();
        tick();
        chk("rst_in_bus", {24'd0, in_bus}, 32'd0);
        chk("rst_ready", {31'd0, ard_data_ready}, 32'd0);
        chk("rst_rr", {31'd0, ard_receive_ready}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_rr", {31'd0, ard_receive_ready}, 32'd1);

        // {ADD,1,0,0,I_TYPE}=1201, {SUB,2,1,0,R_TYPE}=2440, {ADD,1,0,0,R_TYPE}=1200,
        // {LD,1,2,3,M_TYPE}=328E
        preload(16'd0, 16'h1201);
        preload(16'd1, 16'h0005);
        preload(16'd2, 16'h2440);
        preload(16'd4, 16'h1200);
        preload(16'd15, 16'h328E);

        // I_TYPE fetch: two words
        send_addr(1'b1, 1'b0, 16'h0000);
        exp_q = '{8'h01, 8'h12, 8'h05, 8'h00};
        drain("fetch0");

        // R_TYPE fetch: one word; preload during transmit must not disturb it
        send_addr(1'b1, 1'b0, 16'h0004);
        chk("fetch4_b0", {24'd0, in_bus}, 32'h00);
        imem_we    = 1'b1;
        imem_waddr = 16'd4;
        imem_wdata = 16'hFFFF;
        tick();
        imem_we    = 1'b0;
        exp_q = '{8'h12};
        drain("fetch4");

        // store FFFD to dmem[6]
        send_addr(1'b0, 1'b1, 16'h0006);
        bus_mdr = 1'b1;
        out_bus = 8'hFD;
        tick();
        out_bus = 8'hFF;
        tick();
        bus_mdr = 1'b0;
        out_bus = '0;
        dmem_raddr = 16'd6;
        #1;
        chk("store_rdata", {16'd0, dmem_rdata}, 32'h0000FFFD);
        chk("store_no_ready", {31'd0, ard_data_ready}, 32'd0);

        // load back from dmem[6]
        send_addr(1'b0, 1'b1, 16'h0006);
        bus_mdr = 1'b0;
        wait_ready("load", 3);
        exp_q = '{8'hFD, 8'hFF};
        drain("load");

        // reset in the middle of a fetch
        send_addr(1'b1, 1'b0, 16'h0000);
        tick();
        rst_n = 1'b0;
        #1;
        chk("abort_in_bus", {24'd0, in_bus}, 32'd0);
        chk("abort_ready", {31'd0, ard_data_ready}, 32'd0);
        chk("abort_rr", {31'd0, ard_receive_ready}, 32'd0);
        #2;
        rst_n = 1'b1;
        tick();
        chk("abort_idle_rr", {31'd0, ard_receive_ready}, 32'd1);
        send_addr(1'b1, 1'b0, 16'h0002);
        exp_q = '{8'h40, 8'h24};
        drain("fetch2");

        // fetch past the end of imem
        send_addr(1'b1, 1'b0, 16'h0020);
`ifdef SERMEM_BOUNDS_CHECK_EN
        exp_q = '{8'h00, 8'h00};
        drain("oob");
        chk("oob_err", {31'd0, err}, 32'd1);
`else
        exp_q = '{8'h01, 8'h12, 8'h05, 8'h00};
        drain("oob");
        chk("oob_err", {31'd0, err}, 32'd0);
`endif

        // pc+1 wraps from the last word
        send_addr(1'b1, 1'b0, 16'h000F);
`ifdef SERMEM_BOUNDS_CHECK_EN
        exp_q = '{8'h8E, 8'h32, 8'h00, 8'h00};
`else
        exp_q = '{8'h8E, 8'h32, 8'h01, 8'h12};
`endif
        drain("wrap");

        // bus_pc wins over bus_mar; imem[4] now holds the mid-fetch preload (SYS_END)
        send_addr(1'b1, 1'b1, 16'h0004);
        exp_q = '{8'hFF, 8'hFF};
        drain("prio");
`ifdef SERMEM_BOUNDS_CHECK_EN
        chk("prio_err", {31'd0, err}, 32'd1);
`else
        chk("prio_err", {31'd0, err}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
